// File: rtl/disp_pkg.sv
// Shared display constants: scan FSM states, dark segment pattern, index width.
// Also used by the BCD-to-7seg decoder for its segment constants.
package disp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BLANK,
    ST_DRIVE
  } state_t;

  localparam logic [6:0] SEG_OFF = 7'h7F;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/disp_scan_ctrl_if.sv
// Segment/anode bus between scan controller and its driver.
// DISP_SCAN_DIM_EN adds the dim_lvl brightness input.
interface disp_scan_if
  import disp_pkg::*;
#(
  parameter int NUM_DISP = 4
);
  localparam int IDX_W = idx_w(NUM_DISP);

  logic                  en;
  logic [NUM_DISP*7-1:0] seg_in;
`ifdef DISP_SCAN_DIM_EN
  logic [3:0]            dim_lvl;
`endif
  logic [6:0]            seg_out;
  logic [NUM_DISP-1:0]   an_out;
  logic [IDX_W-1:0]      digit_idx;
  logic                  scan_tick;

`ifdef DISP_SCAN_DIM_EN
  modport master (
    output en, seg_in, dim_lvl,
    input  seg_out, an_out, digit_idx, scan_tick
  );
  modport slave (
    input  en, seg_in, dim_lvl,
    output seg_out, an_out, digit_idx, scan_tick
  );
`else
  modport master (
    output en, seg_in,
    input  seg_out, an_out, digit_idx, scan_tick
  );
  modport slave (
    input  en, seg_in,
    output seg_out, an_out, digit_idx, scan_tick
  );
`endif

endinterface

// File: rtl/disp_slot_timer.sv
// Slot counter 0..CLK_DIV-1 with end-of-blank and end-of-slot strobes.
// Synchronous clear on rst, !en, or while the scanner idles.
module disp_slot_timer #(
  parameter int CLK_DIV   = 1000,
  parameter int BLANK_CYC = 8,
  parameter int CW        = $clog2(CLK_DIV)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          hold,
  output logic [CW-1:0] cnt,
  output logic          blank_end,
  output logic          slot_end
);

  assign blank_end = (cnt == CW'(BLANK_CYC - 1));
  assign slot_end  = (cnt == CW'(CLK_DIV - 1));

  always_ff @(posedge clk) begin
    if (rst || !en || hold || slot_end)
      cnt <= '0;
    else
      cnt <= cnt + CW'(1);
  end

endmodule

// File: rtl/disp_scan_ctrl.sv
// Time-multiplexed 7-seg scan scheduler with per-slot blanking.
// Optional DISP_SCAN_DIM_EN shortens the anode-on time per dim_lvl.
module disp_scan_ctrl
  import disp_pkg::*;
#(
  parameter int NUM_DISP  = 4,
  parameter int CLK_DIV   = 1000,
  parameter int BLANK_CYC = 8
) (
  input  logic       clk,
  input  logic       rst,
  disp_scan_if.slave bus
);

  localparam int IDX_W = idx_w(NUM_DISP);
  localparam int CW    = $clog2(CLK_DIV);

  state_t              state, state_n;
  logic [6:0]          seg_q, seg_n;
  logic [NUM_DISP-1:0] an_q, an_n;
  logic [IDX_W-1:0]    idx_q, idx_n;
  logic                tick_q, tick_n;
  logic [CW-1:0]       cnt;
  logic                blank_end;
  logic                slot_end;
  logic [NUM_DISP-1:0] sel;
  logic [6:0]          pat;

`ifdef DISP_SCAN_DIM_EN
  localparam int DIM_STEP = (CLK_DIV - BLANK_CYC) / 16;
  logic [CW:0] lit_q, lit_n;
`endif

  disp_slot_timer #(
    .CLK_DIV  (CLK_DIV),
    .BLANK_CYC(BLANK_CYC),
    .CW       (CW)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .en       (bus.en),
    .hold     (state == ST_IDLE),
    .cnt      (cnt),
    .blank_end(blank_end),
    .slot_end (slot_end)
  );

  assign sel = NUM_DISP'(1) << idx_q;
  assign pat = bus.seg_in[int'(idx_q)*7 +: 7];

  always_comb begin
    state_n = state;
    seg_n   = seg_q;
    an_n    = an_q;
    idx_n   = idx_q;
    tick_n  = 1'b0;
`ifdef DISP_SCAN_DIM_EN
    lit_n   = lit_q;
`endif
    if (!bus.en) begin
      state_n = ST_IDLE;
      seg_n   = SEG_OFF;
      an_n    = '1;
      idx_n   = '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          state_n = ST_BLANK;
          seg_n   = SEG_OFF;
          an_n    = '1;
          idx_n   = '0;
        end
        ST_BLANK: begin
          seg_n = SEG_OFF;
          an_n  = '1;
          if (blank_end) begin
            state_n = ST_DRIVE;
            seg_n   = pat;
            an_n    = ~sel;
`ifdef DISP_SCAN_DIM_EN
            lit_n = (CW+1)'((int'(bus.dim_lvl) + 1) * DIM_STEP);
            if (lit_n == '0)
              an_n = '1;
`endif
          end
        end
        ST_DRIVE: begin
          if (slot_end) begin
            state_n = ST_BLANK;
            seg_n   = SEG_OFF;
            an_n    = '1;
            tick_n  = 1'b1;
            idx_n   = (idx_q == IDX_W'(NUM_DISP - 1)) ?
                      '0 : idx_q + IDX_W'(1);
          end
`ifdef DISP_SCAN_DIM_EN
          // drive cycles elapsed after this edge reach the lit budget
          else if (int'(cnt) + 1 >= int'(lit_q) + BLANK_CYC) begin
            an_n = '1;
          end
`endif
        end
        default: begin
          state_n = ST_IDLE;
          seg_n   = SEG_OFF;
          an_n    = '1;
          idx_n   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      seg_q  <= SEG_OFF;
      an_q   <= '1;
      idx_q  <= '0;
      tick_q <= 1'b0;
`ifdef DISP_SCAN_DIM_EN
      lit_q  <= '0;
`endif
    end else begin
      state  <= state_n;
      seg_q  <= seg_n;
      an_q   <= an_n;
      idx_q  <= idx_n;
      tick_q <= tick_n;
`ifdef DISP_SCAN_DIM_EN
      lit_q  <= lit_n;
`endif
    end
  end

  assign bus.seg_out   = seg_q;
  assign bus.an_out    = an_q;
  assign bus.digit_idx = idx_q;
  assign bus.scan_tick = tick_q;

endmodule

// File: tb/tb_disp_scan_ctrl.sv
// Self-checking bench for disp_scan_ctrl: directed scan checks plus
// randomized en/rst/seg_in traffic against a slot-arithmetic model.
module tb_disp_scan_ctrl;
  import disp_pkg::*;

  localparam int N   = 4;
  localparam int BLK = 2;
`ifdef DISP_SCAN_DIM_EN
  localparam int CD  = 34;
`else
  localparam int CD  = 10;
`endif
  localparam int STEP = (CD - BLK) / 16;

  logic clk;
  logic rst;

  disp_scan_if #(.NUM_DISP(N)) bus ();

  disp_scan_ctrl #(
    .NUM_DISP (N),
    .CLK_DIV  (CD),
    .BLANK_CYC(BLK)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // reference model: position inside the scan derived from elapsed cycles
  bit         armed = 0;
  bit         act = 0;
  int         p = 0;
  int         litlen = 0;
  logic [6:0] lat = 7'h7F;
  logic [6:0] e_seg = 7'h7F;
  logic [N-1:0] e_an = '1;
  int         e_idx = 0;
  logic       e_tick = 0;

  always @(posedge clk) begin
    int pos, dig;
    if (rst || !bus.en) begin
      if (rst) armed = 1;
      act = 0;
      p = 0;
      e_seg = 7'h7F; e_an = '1; e_idx = 0; e_tick = 0;
    end else if (!act) begin
      act = 1;
      p = 0;
      e_seg = 7'h7F; e_an = '1; e_idx = 0; e_tick = 0;
    end else begin
      p++;
      pos = p % CD;
      dig = (p / CD) % N;
      if (pos == BLK) begin
        lat = bus.seg_in[dig*7 +: 7];
`ifdef DISP_SCAN_DIM_EN
        litlen = (int'(bus.dim_lvl) + 1) * STEP;
`else
        litlen = CD - BLK;
`endif
      end
      e_idx  = dig;
      e_tick = (pos == 0);
      e_seg  = (pos >= BLK) ? lat : 7'h7F;
      e_an   = '1;
      if (pos >= BLK && (pos - BLK) < litlen)
        e_an[dig] = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (armed) begin
      vectors++;
      if (bus.seg_out !== e_seg || bus.an_out !== e_an ||
          int'(bus.digit_idx) != e_idx || bus.scan_tick !== e_tick) begin
        miscompares++;
        $display("FAIL model t=%0t got seg=%h an=%b idx=%0d tick=%b want seg=%h an=%b idx=%0d tick=%b",
                 $time, bus.seg_out, bus.an_out, bus.digit_idx, bus.scan_tick,
                 e_seg, e_an, e_idx, e_tick);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got,
                     input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got %h want %h", name, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  int ticks;

  initial begin
    rst = 1'b1;
    bus.en = 1'b1;
    bus.seg_in = {7'h06, 7'h12, 7'h4F, 7'h01};
`ifdef DISP_SCAN_DIM_EN
    bus.dim_lvl = 4'd15;
`endif
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_seg", 32'(bus.seg_out), 32'h7F);
    chk("rst_an", 32'(bus.an_out), 32'hF);
    chk("rst_idx", 32'(bus.digit_idx), 0);
    chk("rst_tick", 32'(bus.scan_tick), 0);
    rst = 1'b0;

    step(BLK + 1);
    chk("d0_an", 32'(bus.an_out), 32'b1110);
    chk("d0_seg", 32'(bus.seg_out), 32'h01);
    step(CD - BLK);
    chk("tick1", 32'(bus.scan_tick), 1);
    chk("gap_an", 32'(bus.an_out), 32'hF);
    step(1);
    chk("tick_once", 32'(bus.scan_tick), 0);
    step(BLK - 1);
    chk("d1_an", 32'(bus.an_out), 32'b1101);
    chk("d1_seg", 32'(bus.seg_out), 32'h4F);
    chk("d1_idx", 32'(bus.digit_idx), 1);

    ticks = 0;
    for (int i = 0; i < 4 * CD; i++) begin
      step(1);
      if (bus.scan_tick) ticks++;
    end
    chk("frame_ticks", 32'(ticks), 4);
    chk("wrap_an", 32'(bus.an_out), 32'b1101);

    step(3 * CD);
    chk("d0_again_an", 32'(bus.an_out), 32'b1110);
    chk("d0_again_seg", 32'(bus.seg_out), 32'h01);
    step(3);
    bus.seg_in[6:0] = 7'h4F;
    step(3);
    chk("hold_seg", 32'(bus.seg_out), 32'h01);
    step(4 * CD - 6);
    chk("next_seg", 32'(bus.seg_out), 32'h4F);
    chk("next_an", 32'(bus.an_out), 32'b1110);

    step(2 * CD);
    chk("d2_an", 32'(bus.an_out), 32'b1011);
    step(2);
    bus.en = 1'b0;
    step(1);
    chk("off_an", 32'(bus.an_out), 32'hF);
    chk("off_seg", 32'(bus.seg_out), 32'h7F);
    chk("off_idx", 32'(bus.digit_idx), 0);
    bus.en = 1'b1;
    step(1);
    chk("re_blank", 32'(bus.an_out), 32'hF);
    step(BLK);
    chk("re_an", 32'(bus.an_out), 32'b1110);
    chk("re_idx", 32'(bus.digit_idx), 0);
    chk("re_seg", 32'(bus.seg_out), 32'h4F);

    for (int i = 0; i < 3000; i++) begin
      int r;
      r = $urandom_range(0, 999);
      rst = (r < 3);
      if (r >= 3 && r < 10)
        bus.en = ~bus.en;
      else if (!bus.en && r < 60)
        bus.en = 1'b1;
      if ($urandom_range(0, 19) == 0)
        bus.seg_in = {$urandom, $urandom};
`ifdef DISP_SCAN_DIM_EN
      bus.dim_lvl = 4'($urandom_range(0, 15));
`endif
      step(1);
    end
    rst = 1'b0;
    step(2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
